// File: rtl/isa_pkg.sv
// Shared ISA definitions: bus widths and the I/O target FSM state encoding.
// Used by the I/O target, the bridge and their benches.
package isa_pkg;

  localparam int ISA_ADDR_W = 10;
  localparam int ISA_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVE,
    ST_HOLD
  } isa_state_e;

endpackage

// File: rtl/isa_sync.sv
// Multi-stage synchronizer for an asynchronous, active-low ISA strobe.
// Every stage resets to 1, so the strobe reads as inactive out of reset.
// Ports:
//   clk    - system clock
//   nRESET - synchronous, active-low reset
//   d      - asynchronous input
//   q      - synchronized output (STAGES clk cycles of latency)
module isa_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nRESET,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/isa_io_target.sv
// ISA 8-bit I/O target. Decodes SA against a NUM_REGS-aligned window,
// stretches the cycle with IOCHRDY, drives read data and captures write
// data into a local register file that the local side can also access.
//
// Bus handshake: a cycle starts when exactly one synchronized strobe
// (nIOR or nIOW) is low while SA hits the window. The target holds
// nIOCHRDY_oe for WAIT_STATES cycles, then the cycle completes when the
// host releases the strobe: rd_stb/wr_stb pulse for one cycle and
// acc_addr records the index. A strobe released while IOCHRDY is still
// held aborts the cycle with no side effects. Both strobes low at once is
// a bus error (err_stb) and forces the target back to idle.
//
// Ports:
//   clk, nRESET       - clock, synchronous active-low reset
//   SA, nIOR, nIOW    - ISA address and asynchronous strobes
//   SD_in             - ISA data from bus
//   SD_out, SD_oe     - ISA data to bus and its output enable
//   nIOCHRDY_oe       - 1 = pull IOCHRDY low
//   loc_addr/wdata/we - local register write port
//   loc_rdata         - combinational read of regs[loc_addr]
//   wr_stb, rd_stb    - one-cycle pulses on committed ISA write/read
//   acc_addr          - register index of the last committed access
//   err_stb           - one-cycle pulse when both strobes go low
//   dbg_state         - current FSM state
module isa_io_target
  import isa_pkg::*;
#(
  parameter logic [ISA_ADDR_W-1:0] BASE_ADDR   = 10'h300,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 2,
  parameter int                    SYNC_STAGES = 2,
  localparam int                   IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  nRESET,
  input  logic [ISA_ADDR_W-1:0] SA,
  input  logic                  nIOR,
  input  logic                  nIOW,
  input  logic [ISA_DATA_W-1:0] SD_in,
  output logic [ISA_DATA_W-1:0] SD_out,
  output logic                  SD_oe,
  output logic                  nIOCHRDY_oe,
  input  logic [IDX_W-1:0]      loc_addr,
  input  logic [ISA_DATA_W-1:0] loc_wdata,
  input  logic                  loc_we,
  output logic [ISA_DATA_W-1:0] loc_rdata,
  output logic                  wr_stb,
  output logic                  rd_stb,
  output logic [IDX_W-1:0]      acc_addr,
  output logic                  err_stb,
  output isa_state_e            dbg_state
);

  localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  logic nior_sync, niow_sync;
  logic ior_s, iow_s, both, dir_str, hit;

  isa_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    dir_wr_q, dir_wr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ISA_DATA_W-1:0]   wdata_q, wdata_d;
  logic                    both_q;
  logic                    isa_commit;

  logic [ISA_DATA_W-1:0]   sd_out_d;
  logic                    sd_oe_d, rdy_d, wr_stb_d, rd_stb_d, err_d;
  logic [IDX_W-1:0]        acc_d;

  logic [ISA_DATA_W-1:0]   regs [NUM_REGS];

  isa_sync #(.STAGES(SYNC_STAGES)) u_sync_ior (
    .clk    (clk),
    .nRESET (nRESET),
    .d      (nIOR),
    .q      (nior_sync)
  );

  isa_sync #(.STAGES(SYNC_STAGES)) u_sync_iow (
    .clk    (clk),
    .nRESET (nRESET),
    .d      (nIOW),
    .q      (niow_sync)
  );

  assign ior_s   = ~nior_sync;
  assign iow_s   = ~niow_sync;
  assign both    = ior_s & iow_s;
  // The strobe that owns the cycle in progress.
  assign dir_str = dir_wr_q ? iow_s : ior_s;
  assign hit     = (SA[ISA_ADDR_W-1:IDX_W] == BASE_ADDR[ISA_ADDR_W-1:IDX_W]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dir_wr_d   = dir_wr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    sd_out_d   = SD_out;
    sd_oe_d    = SD_oe;
    rdy_d      = nIOCHRDY_oe;
    acc_d      = acc_addr;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;
    isa_commit = 1'b0;
    // Pulse only on the first cycle of an overlap.
    err_d      = both & ~both_q;

    if (both) begin
      state_d  = ST_IDLE;
      sd_oe_d  = 1'b0;
      sd_out_d = '0;
      rdy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((ior_s ^ iow_s) && hit) begin
            idx_d    = SA[IDX_W-1:0];
            dir_wr_d = iow_s;
            cnt_d    = CNT_W'(WAIT_STATES);
            rdy_d    = (WAIT_STATES > 0);
            if (!iow_s) begin
              sd_oe_d  = 1'b1;
              sd_out_d = regs[SA[IDX_W-1:0]];
            end
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!dir_str) begin
            // Host gave up before IOCHRDY was released.
            rdy_d   = 1'b0;
            sd_oe_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            if (dir_wr_q) begin
              wdata_d = SD_in;
            end else begin
              sd_out_d = regs[idx_q];
            end
            // Counting down to 1 keeps IOCHRDY low for exactly WAIT_STATES
            // cycles; a count of 0 still spends one cycle here.
            if (cnt_q <= CNT_W'(1)) begin
              rdy_d   = 1'b0;
              state_d = ST_ACTIVE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (dir_wr_q) begin
            if (iow_s) begin
              wdata_d = SD_in;
            end else begin
              isa_commit = 1'b1;
              wr_stb_d   = 1'b1;
              acc_d      = idx_q;
              state_d    = ST_HOLD;
            end
          end else begin
            if (ior_s) begin
              sd_out_d = regs[idx_q];
            end else begin
              sd_oe_d  = 1'b0;
              rd_stb_d = 1'b1;
              acc_d    = idx_q;
              state_d  = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!ior_s && !iow_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dir_wr_q    <= 1'b0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      both_q      <= 1'b0;
      SD_out      <= '0;
      SD_oe       <= 1'b0;
      nIOCHRDY_oe <= 1'b0;
      wr_stb      <= 1'b0;
      rd_stb      <= 1'b0;
      err_stb     <= 1'b0;
      acc_addr    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dir_wr_q    <= dir_wr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      both_q      <= both;
      SD_out      <= sd_out_d;
      SD_oe       <= sd_oe_d;
      nIOCHRDY_oe <= rdy_d;
      wr_stb      <= wr_stb_d;
      rd_stb      <= rd_stb_d;
      err_stb     <= err_d;
      acc_addr    <= acc_d;
    end
  end

  // Register file; the ISA commit is written last so it wins a same-index
  // collision with the local port.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (loc_we) begin
        regs[loc_addr] <= loc_wdata;
      end
      if (isa_commit) begin
        regs[idx_q] <= wdata_q;
      end
    end
  end

  assign loc_rdata = regs[loc_addr];
  assign dbg_state = state_q;

endmodule

// File: doc/isa_io_target.md
Name: isa_io_target

Overview:
- ISA 8-bit I/O responder: the target end of the nIOR/nIOW strobes that the bridge drives onto the ISA bus.
- Decodes SA against a base window, inserts IOCHRDY wait states, returns read data and captures write data into a local register file.
- Used as an on-board peripheral target and as the bench counterpart for the bridge strobe logic.
- Everything is sampled on clk; ISA inputs are asynchronous and are synchronized inside the block.

Parameters:
- BASE_ADDR, 10'h300, base of the decoded I/O window; must be aligned to NUM_REGS.
- NUM_REGS, 8, number of 8-bit registers; power of 2, range 2..64.
- WAIT_STATES, 2, clk cycles IOCHRDY is held low after a decode hit; 0 means never pulled low.
- SYNC_STAGES, 2, synchronizer depth on nIOR/nIOW; minimum 2.

Ports:
- clk  in  1  system clock
- nRESET  in  1  synchronous, active-low reset
- SA  in  10  ISA address
- nIOR  in  1  ISA I/O read strobe, active low, asynchronous
- nIOW  in  1  ISA I/O write strobe, active low, asynchronous
- SD_in  in  8  ISA data from bus
- SD_out  out  8  ISA data to bus
- SD_oe  out  1  data bus output enable
- nIOCHRDY_oe  out  1  high = pull IOCHRDY low (open-drain enable)
- loc_addr  in  log2(NUM_REGS)  local read/write index
- loc_wdata  in  8  local write data
- loc_we  in  1  local write enable
- loc_rdata  out  8  combinational read of regs[loc_addr]
- wr_stb  out  1  one-cycle pulse: ISA write committed
- rd_stb  out  1  one-cycle pulse: ISA read completed
- acc_addr  out  log2(NUM_REGS)  register index of the last committed access
- err_stb  out  1  one-cycle pulse: nIOR and nIOW both low

Behaviour:
- Decomposition: one clock domain (clk) and one reset; reset is synchronous and active-low, named nRESET.
- Reset values: SD_out=0, SD_oe=0, nIOCHRDY_oe=0, wr_stb=rd_stb=err_stb=0, acc_addr=0, all regs=0, FSM=IDLE, synchronizer flops=1 (strobes inactive).
- Synchronization: nIOR/nIOW pass through SYNC_STAGES flops; ior_s/iow_s are the synchronized active-high strobes. SA and SD_in are sampled only when the FSM transitions, after the strobe has been synchronized.
- Hit: SA[9:log2(NUM_REGS)] == BASE_ADDR[9:log2(NUM_REGS)].
- FSM states IDLE, WAIT, ACTIVE, HOLD:
- IDLE: ior_s XOR iow_s, with a hit -> latch idx=SA low bits and dir, load wait counter=WAIT_STATES, set nIOCHRDY_oe=1 if WAIT_STATES>0, go WAIT. For a read, SD_oe=1 and SD_out=regs[idx] on the same registered edge. A miss stays IDLE with no output activity.
- ior_s AND iow_s in any state: err_stb pulses once per occurrence (rising of the AND). All outputs go to idle values and the FSM returns to IDLE, or stays there; no register is written.
- WAIT: counter decrements each cycle; at 0, nIOCHRDY_oe=0 and go ACTIVE. WAIT_STATES=0 passes through WAIT in one cycle.
- ACTIVE, read: SD_out tracks regs[idx] each cycle. When ior_s falls: SD_oe=0, rd_stb=1, acc_addr=idx, go HOLD.
- ACTIVE, write: SD_in is registered every cycle while iow_s=1. When iow_s falls, the last registered value is written to regs[idx], with wr_stb=1 and acc_addr=idx; go HOLD.
- Abort: the strobe deasserts while in WAIT -> release IOCHRDY and SD_oe, no write, no rd_stb/wr_stb, go IDLE.
- HOLD: wait until both ior_s=0 and iow_s=0 (one cycle minimum), then go IDLE. This blocks re-triggering on a single strobe.
- Local writes: loc_we writes regs[loc_addr] any cycle. If it coincides with an ISA commit to the same index, the ISA write wins.
- Pin-to-output latency: SD_oe and nIOCHRDY_oe assert SYNC_STAGES+1 clk cycles after the strobe pin falls.
- Reset mid-operation: all outputs return to reset values on the next edge, including SD_oe and nIOCHRDY_oe; no pending write is committed.

Decomposition:
- Package isa_pkg holds the FSM state enum, ISA address width (10) and data width (8) constants, shared with the bridge and its bench.
- One sub-module, isa_sync: parameterized multi-stage synchronizer with reset-to-1, instantiated once for each of the two strobes.

Test Plan:
- Read hit: regs[3]=8'hA5 via loc_we; SA=0x303, nIOR low 12 cycles -> nIOCHRDY_oe high exactly 2 cycles; SD_oe high with SD_out=A5 until 3 cycles after nIOR rises; rd_stb pulse with acc_addr=3.
- Write hit: SA=0x305, SD_in=0x3C, nIOW low 10 cycles -> after nIOW rises, regs[5]=3C, wr_stb single pulse with acc_addr=5, loc_rdata(5)=3C.
- Miss: SA=0x2F0 and 0x308 with nIOR low -> SD_oe, nIOCHRDY_oe and all strobes stay 0.
- Abort: SA=0x301 write with nIOW low 2 cycles and WAIT_STATES=4 -> nIOCHRDY_oe released, regs[1] unchanged, no wr_stb.
- Conflict: nIOR and nIOW low together -> single err_stb, SD_oe=0, no register change. Same-cycle ISA commit and loc_we to index 2 -> regs[2]=ISA data.
- Reset mid-read: nRESET low during ACTIVE -> SD_oe=0 and nIOCHRDY_oe=0 next edge, all regs=0; a subsequent read of 0x300 returns 00.
